keypad_emulator: RTL
====================

// Module: keypad_emulator
// PURPOSE
//  Device-side model of the 4x4 Pmod keypad matrix: samples column drives from the scanner and returns active-low row lines.
//  Key presses come from a command queue (key code, hold time) and play back with optional contact bounce.
//  Sits opposite the keypad scanner in loopback builds and benches, replacing the physical keypad.
// PARAMETERS
//  FIFO_DEPTH    4    command queue entries (power of 2, >=2)
//  BOUNCE_CYCLES 64   bounce window length at press and release edges; 0 disables bounce
//  GAP_CYCLES    256  minimum released time between consecutive queued presses
//  LFSR_SEED     16'hACE1  reset value of bounce LFSR (nonzero)
// PORTS
//  i_Clock       in   1   system clock
//  i_Reset_n     in   1   asynchronous active-low reset
//  i_Columns     in   4   column drives from scanner, active-low; [3]=col0 .. [0]=col3
//  o_Rows        out  4   row lines to scanner, active-low; [3]=top row .. [0]=bottom row
//  i_Cmd_Valid   in   1   command present
//  o_Cmd_Ready   out  1   queue can accept command
//  i_Cmd_Key     in   4   key code 0x0-0xF to press
//  i_Cmd_Hold    in   16  stable-pressed cycles (0 treated as 1)
//  i_Force_Mask  in   16  keys held statically pressed, bit n = key n; ORed with played key
//  o_Key_Active  out  1   played key contact currently closed (post-bounce)
//  o_Busy        out  1   queue non-empty or FSM not IDLE
//  o_Done        out  1   one-cycle pulse when a command's GAP completes
// BEHAVIOUR
//  Reset: o_Rows=4'hF, o_Cmd_Ready=1, o_Key_Active=0, o_Busy=0, o_Done=0, queue empty, FSM IDLE, LFSR=LFSR_SEED.
//  Matrix layout (col0..col3 x top..bottom): col0={1,4,7,0} col1={2,5,8,F} col2={3,6,9,E} col3={A,B,C,D}.
//  Pressed set P = i_Force_Mask | (contact ? onehot(current key) : 0).
//  o_Rows[r] = 0 iff some column c has i_Columns bit low and key(c,r) in P; multiple low columns OR together.
//  o_Rows registered: reflects i_Columns/P of previous cycle (1-cycle latency); no combinational path in->out.
//  Queue: push on i_Cmd_Valid && o_Cmd_Ready; o_Cmd_Ready = !full (registered occupancy).
//   Push while full is dropped. Push and pop in same cycle allowed when not full; occupancy unchanged.
//  FSM (16-bit down-counter cnt):
//   IDLE: queue non-empty -> pop, latch key/hold, cnt=BOUNCE_CYCLES-1 -> BOUNCE_IN (or HOLD if BOUNCE_CYCLES=0).
//   BOUNCE_IN: contact = LFSR[0] each cycle; cnt==0 -> cnt=max(hold,1)-1 -> HOLD.
//   HOLD: contact=1; cnt==0 -> BOUNCE_OUT (or GAP if BOUNCE_CYCLES=0), reload cnt.
//   BOUNCE_OUT: contact = LFSR[0]; cnt==0 -> cnt=GAP_CYCLES-1 -> GAP.
//   GAP: contact=0; cnt==0 -> o_Done=1 for one cycle -> IDLE (same-cycle pop of next command not allowed; next starts next cycle).
//  Bounce LFSR: 16-bit Fibonacci x^16+x^14+x^13+x^11+1, steps only in BOUNCE_* states.
//  o_Key_Active = contact, registered with o_Rows so both change in the same cycle.
//  Counter widths: hold is exactly 16-bit; no wrap. Hold 0xFFFF gives 65535 stable cycles.
//  Reset asserted mid-command: command and queue contents discarded; rows release immediately (async) to 4'hF.
//  i_Force_Mask change takes effect on o_Rows after 1 cycle regardless of FSM state.
// STRUCTURE
//  Shared package keypad_pkg: FSM state encodings; KEY_COL/KEY_ROW lookup (key code -> col,row), shared with scanner decoder;
//   LFSR taps constant.
//  Sub-module keypad_cmd_fifo (parameterised depth/width, 20-bit entries {hold,key}, async active-low reset, full/empty flags).
//  Top: FSM + counter + LFSR + row matrix logic.
// TESTING
//  1 Reset: hold i_Reset_n=0 with i_Force_Mask=16'hFFFF, i_Columns=0 -> o_Rows=4'hF, o_Cmd_Ready=1, o_Busy=0.
//  2 Static map: i_Force_Mask=1<<4 (key 4), i_Columns=4'b0111 -> o_Rows=4'b1011 next cycle; i_Columns=4'b1011 -> 4'hF.
//  3 Playback, BOUNCE_CYCLES=0, GAP_CYCLES=4: push key 0xD hold 10, i_Columns=4'b1110 -> o_Rows=4'b1110 for exactly 10 cycles,
//    then 4'hF; o_Done pulses once 4 cycles after release; o_Busy drops the cycle after o_Done.
//  4 Queue full, FIFO_DEPTH=4: push 6 commands back-to-back while FSM busy -> first accepted command popped, 4 queued,
//    6th dropped with o_Cmd_Ready=0; exactly 5 o_Done pulses.
//  5 Bounce: BOUNCE_CYCLES=64, key 1 hold 100, col0 driven -> o_Key_Active toggles >=1 time in first 64 cycles, stable 1 for
//    100 cycles, toggles in next 64; scanner loopback eventually decodes key 0x1.
//  6 Reset mid-HOLD: assert i_Reset_n=0 during HOLD -> o_Rows=4'hF asynchronously, queue empty after release, no o_Done.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: FSM states, key-code to matrix position lookup, bounce LFSR taps.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_HOLD,
        ST_BOUNCE_OUT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [15:0] hold;
        logic [3:0]  key;
    } cmd_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form over bits [15],[13],[12],[10]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [1:0] key_col(input logic [3:0] key);
        case (key)
            4'h1, 4'h4, 4'h7, 4'h0: key_col = 2'd0;
            4'h2, 4'h5, 4'h8, 4'hF: key_col = 2'd1;
            4'h3, 4'h6, 4'h9, 4'hE: key_col = 2'd2;
            default:                key_col = 2'd3;
        endcase
    endfunction

    function automatic logic [1:0] key_row(input logic [3:0] key);
        case (key)
            4'h1, 4'h2, 4'h3, 4'hA: key_row = 2'd0;
            4'h4, 4'h5, 4'h6, 4'hB: key_row = 2'd1;
            4'h7, 4'h8, 4'h9, 4'hC: key_row = 2'd2;
            default:                key_row = 2'd3;
        endcase
    endfunction

    // Counter reload for a hold time; zero is played as a single cycle.
    function automatic logic [15:0] hold_load(input logic [15:0] hold);
        hold_load = (hold == 16'd0) ? 16'd0 : hold - 16'd1;
    endfunction

endpackage

// File: rtl/keypad_cmd_fifo.sv
// Command queue: head data visible combinationally, full/empty from registered occupancy.
// Push visible one cycle later; push while full is dropped, pop while empty ignored.
module keypad_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Push,
    input  logic [WIDTH-1:0] i_Data,
    input  logic             i_Pop,
    output logic [WIDTH-1:0] o_Data,
    output logic             o_Full,
    output logic             o_Empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign o_Full  = (count == (AW+1)'(DEPTH));
    assign o_Empty = (count == '0);
    assign o_Data  = mem[rd_ptr];
    assign push_ok = i_Push && !o_Full;
    assign pop_ok  = i_Pop && !o_Empty;

    always_ff @(posedge i_Clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= i_Data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// 4x4 keypad device model: queued presses played back with optional bounce onto active-low rows.
// Rows and key-active are registered (1-cycle latency); command input backpressured only when the queue is full.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int          FIFO_DEPTH    = 4,
    parameter int          BOUNCE_CYCLES = 64,
    parameter int          GAP_CYCLES    = 256,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic [3:0]  i_Columns,
    output logic [3:0]  o_Rows,
    input  logic        i_Cmd_Valid,
    output logic        o_Cmd_Ready,
    input  logic [3:0]  i_Cmd_Key,
    input  logic [15:0] i_Cmd_Hold,
    input  logic [15:0] i_Force_Mask,
    output logic        o_Key_Active,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam bit          HAS_BOUNCE  = (BOUNCE_CYCLES > 0);
    localparam logic [15:0] BOUNCE_LOAD = HAS_BOUNCE ? 16'(BOUNCE_CYCLES - 1) : 16'd0;
    localparam logic [15:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  key_q;
    logic [3:0]  key_nxt;
    logic [15:0] hold_q;
    logic [15:0] hold_nxt;
    logic [15:0] lfsr;
    logic        lfsr_step;
    logic        contact;
    logic        done;
    logic [15:0] pressed;
    logic [3:0]  rows_nxt;
    logic [3:0]  rows_q;
    logic        key_active_q;

    cmd_t        cmd_in;
    cmd_t        fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    assign cmd_in = {i_Cmd_Hold, i_Cmd_Key};

    keypad_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_cmd_fifo (
        .i_Clock   (i_Clock),
        .i_Reset_n (i_Reset_n),
        .i_Push    (i_Cmd_Valid),
        .i_Data    (cmd_in),
        .i_Pop     (fifo_pop),
        .o_Data    (fifo_head),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        key_nxt   = key_q;
        hold_nxt  = hold_q;
        contact   = 1'b0;
        lfsr_step = 1'b0;
        done      = 1'b0;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    key_nxt  = fifo_head.key;
                    hold_nxt = fifo_head.hold;
                    if (HAS_BOUNCE) begin
                        cnt_nxt   = BOUNCE_LOAD;
                        state_nxt = ST_BOUNCE_IN;
                    end else begin
                        cnt_nxt   = hold_load(fifo_head.hold);
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_BOUNCE_IN: begin
                contact   = lfsr[0];
                lfsr_step = 1'b1;
                cnt_nxt   = cnt - 16'd1;
                if (cnt == 16'd0) begin
                    cnt_nxt   = hold_load(hold_q);
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                contact = 1'b1;
                cnt_nxt = cnt - 16'd1;
                if (cnt == 16'd0) begin
                    if (HAS_BOUNCE) begin
                        cnt_nxt   = BOUNCE_LOAD;
                        state_nxt = ST_BOUNCE_OUT;
                    end else begin
                        cnt_nxt   = GAP_LOAD;
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_BOUNCE_OUT: begin
                contact   = lfsr[0];
                lfsr_step = 1'b1;
                cnt_nxt   = cnt - 16'd1;
                if (cnt == 16'd0) begin
                    cnt_nxt   = GAP_LOAD;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_nxt = cnt - 16'd1;
                if (cnt == 16'd0) begin
                    // Returning to IDLE here means the next pop waits one cycle.
                    done      = 1'b1;
                    cnt_nxt   = 16'd0;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A low column pulls down every row holding a pressed key in that column.
    always_comb begin
        pressed  = i_Force_Mask | (contact ? (16'h1 << key_q) : 16'h0);
        rows_nxt = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (pressed[k] && !i_Columns[~key_col(4'(k))]) begin
                rows_nxt[~key_row(4'(k))] = 1'b0;
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state        <= ST_IDLE;
            cnt          <= 16'd0;
            key_q        <= 4'd0;
            hold_q       <= 16'd0;
            lfsr         <= LFSR_SEED;
            rows_q       <= 4'hF;
            key_active_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            key_q        <= key_nxt;
            hold_q       <= hold_nxt;
            rows_q       <= rows_nxt;
            key_active_q <= contact;
            if (lfsr_step) begin
                lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
            end
        end
    end

    assign o_Rows       = rows_q;
    assign o_Key_Active = key_active_q;
    assign o_Cmd_Ready  = !fifo_full;
    assign o_Busy       = !fifo_empty || (state != ST_IDLE);
    assign o_Done       = done;

endmodule
